// File: rtl/execute_stage_p.sv
// EX stage of the hybrid ARM/MIPS pipeline: operand select, ALU, NZCV flags, condition check,
// branch resolve, iterative shift-add multiplier and the EX/MEM pipeline register.
module execute_stage_p #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              reg_write_i,
    input  logic              mem_write_i,
    input  logic              mem_p_write_i,
    input  logic              branch_inst_i,
    input  logic              alu_src_i,
    input  logic              flag_write_i,
    input  logic              io_flag_i,
    input  logic [1:0]        mem_to_reg_i,
    input  logic [3:0]        alu_control_i,
    input  logic [2:0]        cond_flag_i,
    input  logic [WIDTH-1:0]  ra_i,
    input  logic [WIDTH-1:0]  rb_i,
    input  logic [WIDTH-1:0]  ext_im_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              pc_src_o,
    output logic              busy_o,
    output logic [3:0]        flags_o,
    output logic              out_valid_o,
    output logic              reg_write_out_o,
    output logic              mem_write_out_o,
    output logic              mem_p_write_out_o,
    output logic              io_flag_out_o,
    output logic [1:0]        mem_to_reg_out_o,
    output logic [WIDTH-1:0]  alu_result_o,
    output logic [WIDTH-1:0]  write_data_o,
    output logic [REG_AW-1:0] rd_out_o
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              mem_p_write;
        logic              io_flag;
        logic [1:0]        mem_to_reg;
        logic [WIDTH-1:0]  alu_result;
        logic [WIDTH-1:0]  write_data;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    // Flags are {N,Z,C,V}; evaluated against the value held before this instruction.
    function automatic logic cond_check(input logic [2:0] cc, input logic [3:0] f);
        logic res;
        case (cc)
            3'b000:  res = 1'b1;
            3'b001:  res = f[2];
            3'b010:  res = ~f[2];
            3'b011:  res = (f[3] == f[0]);
            3'b100:  res = (f[3] != f[0]);
            3'b101:  res = ~f[2] & (f[3] == f[0]);
            3'b110:  res = f[2] | (f[3] != f[0]);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic              mflag_write_q, mflag_write_d;
    exmem_t            mul_ctl_q, mul_ctl_d;
    exmem_t            exmem_q, exmem_d;
    logic [3:0]        flags_q, flags_d;

    logic [WIDTH-1:0]  src_b_s;
    logic [SHW-1:0]    shamt_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    diff_s;
    logic [WIDTH-1:0]  alu_res_s;
    logic              alu_c_s;
    logic              alu_v_s;
    logic              alu_cv_upd_s;
    logic [WIDTH-1:0]  mul_sum_s;
    logic              cond_pass_s;
    logic              idle_s;
    exmem_t            issue_s;

    assign src_b_s     = alu_src_i ? ext_im_i : rb_i;
    assign shamt_s     = src_b_s[SHW-1:0];
    assign sum_s       = {1'b0, ra_i} + {1'b0, src_b_s};
    assign diff_s      = {1'b0, ra_i} + {1'b0, ~src_b_s} + {{WIDTH{1'b0}}, 1'b1};
    assign mul_sum_s   = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
    assign cond_pass_s = cond_check(cond_flag_i, flags_q);
    assign idle_s      = (state_q == ST_IDLE);

    assign pc_src_o = in_valid_i & branch_inst_i & cond_pass_s & ~stall_i & ~flush_i & idle_s;
    assign busy_o   = stall_i | ~idle_s |
                      (in_valid_i & (alu_control_i == OP_MUL) & cond_pass_s & idle_s);

    // Single-cycle ALU result and the carry/overflow it produces.
    always_comb begin
        alu_res_s    = {WIDTH{1'b0}};
        alu_c_s      = 1'b0;
        alu_v_s      = 1'b0;
        alu_cv_upd_s = 1'b0;
        case (alu_control_i)
            OP_AND: alu_res_s = ra_i & src_b_s;
            OP_ADD: begin
                alu_res_s    = sum_s[WIDTH-1:0];
                alu_c_s      = sum_s[WIDTH];
                alu_v_s      = (ra_i[WIDTH-1] == src_b_s[WIDTH-1]) &&
                               (sum_s[WIDTH-1] != ra_i[WIDTH-1]);
                alu_cv_upd_s = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res_s    = diff_s[WIDTH-1:0];
                alu_c_s      = diff_s[WIDTH];
                alu_v_s      = (ra_i[WIDTH-1] != src_b_s[WIDTH-1]) &&
                               (diff_s[WIDTH-1] != ra_i[WIDTH-1]);
                alu_cv_upd_s = 1'b1;
            end
            OP_ORR: alu_res_s = ra_i | src_b_s;
            OP_EOR: alu_res_s = ra_i ^ src_b_s;
            OP_LSL: alu_res_s = ra_i << shamt_s;
            OP_LSR: alu_res_s = ra_i >> shamt_s;
            OP_ASR: alu_res_s = $signed(ra_i) >>> shamt_s;
            OP_MOV: alu_res_s = src_b_s;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // EX/MEM image of the instruction currently presented.
    always_comb begin
        issue_s             = '0;
        issue_s.valid       = 1'b1;
        issue_s.reg_write   = reg_write_i;
        issue_s.mem_write   = mem_write_i;
        issue_s.mem_p_write = mem_p_write_i;
        issue_s.io_flag     = io_flag_i;
        issue_s.mem_to_reg  = mem_to_reg_i;
        issue_s.alu_result  = alu_res_s;
        issue_s.write_data  = rb_i;
        issue_s.rd          = rd_i;
    end

    // Next state: flush beats stall; MUL runs one shift-add step per unstalled edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        mflag_write_d = mflag_write_q;
        mul_ctl_d     = mul_ctl_q;
        exmem_d       = exmem_q;
        flags_d       = flags_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = {CNTW{1'b0}};
            exmem_d = '0;
        end else if (stall_i) begin
            exmem_d = exmem_q;
        end else if (state_q == ST_MUL) begin
            acc_d    = mul_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
                state_d            = ST_IDLE;
                exmem_d            = mul_ctl_q;
                exmem_d.alu_result = mul_sum_s;
                if (mflag_write_q) begin
                    flags_d = {mul_sum_s[WIDTH-1], ~|mul_sum_s, flags_q[1:0]};
                end else begin
                    flags_d = flags_q;
                end
            end else begin
                exmem_d = '0;
            end
        end else if (in_valid_i && cond_pass_s) begin
            if (alu_control_i == OP_MUL) begin
                state_d       = ST_MUL;
                cnt_d         = CNTW'(WIDTH);
                acc_d         = {WIDTH{1'b0}};
                mcand_d       = ra_i;
                mplier_d      = src_b_s;
                mflag_write_d = flag_write_i;
                mul_ctl_d     = issue_s;
                exmem_d       = '0;
            end else begin
                exmem_d = issue_s;
                if (flag_write_i) begin
                    flags_d = {alu_res_s[WIDTH-1], ~|alu_res_s,
                               alu_cv_upd_s ? alu_c_s : flags_q[1],
                               alu_cv_upd_s ? alu_v_s : flags_q[0]};
                end else begin
                    flags_d = flags_q;
                end
            end
        end else begin
            exmem_d = '0;
        end
    end

    // State, multiplier datapath, flags and EX/MEM register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNTW{1'b0}};
            acc_q         <= {WIDTH{1'b0}};
            mcand_q       <= {WIDTH{1'b0}};
            mplier_q      <= {WIDTH{1'b0}};
            mflag_write_q <= 1'b0;
            mul_ctl_q     <= '0;
            exmem_q       <= '0;
            flags_q       <= 4'b0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            mflag_write_q <= mflag_write_d;
            mul_ctl_q     <= mul_ctl_d;
            exmem_q       <= exmem_d;
            flags_q       <= flags_d;
        end
    end

    assign flags_o           = flags_q;
    assign out_valid_o       = exmem_q.valid;
    assign reg_write_out_o   = exmem_q.reg_write;
    assign mem_write_out_o   = exmem_q.mem_write;
    assign mem_p_write_out_o = exmem_q.mem_p_write;
    assign io_flag_out_o     = exmem_q.io_flag;
    assign mem_to_reg_out_o  = exmem_q.mem_to_reg;
    assign alu_result_o      = exmem_q.alu_result;
    assign write_data_o      = exmem_q.write_data;
    assign rd_out_o          = exmem_q.rd;

endmodule

// File: tb/tb_execute_stage_p.sv
// Self-checking bench for execute_stage_p: scoreboard of retired results plus per-scenario checks.
module tb_execute_stage_p;

    localparam int W  = 32;
    localparam int AW = 4;

    localparam logic [3:0] AND_ = 4'b0000, ADD_ = 4'b0001, SUB_ = 4'b0010, EOR_ = 4'b0100;
    localparam logic [3:0] MUL_ = 4'b1000, CMP_ = 4'b1010;
    localparam logic [2:0] AL = 3'b000, EQ = 3'b001, NE = 3'b010, GE = 3'b011, LT = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, stall, flush, reg_write, mem_write, mem_p_write;
    logic          branch, alu_src, flag_write, io_flag;
    logic [1:0]    mem_to_reg;
    logic [3:0]    alu_control;
    logic [2:0]    cond;
    logic [W-1:0]  ra, rb, ext_im;
    logic [AW-1:0] rd;
    logic          pc_src, busy, out_valid, rw_out, mw_out, mpw_out, io_out;
    logic [3:0]    flags;
    logic [1:0]    m2r_out;
    logic [W-1:0]  alu_result, write_data;
    logic [AW-1:0] rd_out;

    execute_stage_p #(.WIDTH(W), .REG_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .stall_i(stall), .flush_i(flush),
        .reg_write_i(reg_write), .mem_write_i(mem_write), .mem_p_write_i(mem_p_write),
        .branch_inst_i(branch), .alu_src_i(alu_src), .flag_write_i(flag_write),
        .io_flag_i(io_flag), .mem_to_reg_i(mem_to_reg), .alu_control_i(alu_control),
        .cond_flag_i(cond), .ra_i(ra), .rb_i(rb), .ext_im_i(ext_im), .rd_i(rd),
        .pc_src_o(pc_src), .busy_o(busy), .flags_o(flags), .out_valid_o(out_valid),
        .reg_write_out_o(rw_out), .mem_write_out_o(mw_out), .mem_p_write_out_o(mpw_out),
        .io_flag_out_o(io_out), .mem_to_reg_out_o(m2r_out), .alu_result_o(alu_result),
        .write_data_o(write_data), .rd_out_o(rd_out)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [W-1:0]  wd;
        logic [AW-1:0] rd;
        logic          rw;
        logic [1:0]    m2r;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [W-1:0] model_alu(input logic [3:0] op, input logic [W-1:0] a, b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a & b;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return W'($signed(a) >>> sh);
            4'd9:    return b;
            4'd10:   return a - b;
            default: return '0;
        endcase
    endfunction

    task automatic clear_in();
        in_valid = 0; stall = 0; flush = 0; reg_write = 0; mem_write = 0; mem_p_write = 0;
        branch = 0; alu_src = 0; flag_write = 0; io_flag = 0; mem_to_reg = 0;
        alu_control = 0; cond = 0; ra = 0; rb = 0; ext_im = 0; rd = 0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, b, imm, input logic src,
                         input logic [2:0] cc, input logic rwi, fw, br,
                         input logic [AW-1:0] d, input logic [1:0] m2r);
        in_valid = 1; alu_control = op; ra = a; rb = b; ext_im = imm; alu_src = src;
        cond = cc; reg_write = rwi; flag_write = fw; branch = br; rd = d; mem_to_reg = m2r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        tick();
        tick();
        n_checks++;
        if ({out_valid, rw_out, mw_out, mpw_out, io_out, m2r_out, alu_result, write_data, rd_out, flags, busy, pc_src} !== '0) begin
            n_fail++;
            $display("FAIL reset: valid=%b res=%h flags=%b busy=%b required all zero", out_valid, alu_result, flags, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        drive(ADD_, 10, 11, 0, 0, AL, 1, 0, 0, 10, 2'b01);
        sb.push_back('{res: 21, wd: 11, rd: 10, rw: 1, m2r: 2'b01});
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL add_reg: out_valid=%b required 1", out_valid);
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || rd_out !== e.rd || rw_out !== e.rw || m2r_out !== e.m2r) begin
                n_fail++;
                $display("FAIL add_reg: res=%0d rd=%0d rw=%b m2r=%b required %0d %0d %b %b",
                         alu_result, rd_out, rw_out, m2r_out, e.res, e.rd, e.rw, e.m2r);
            end
        end
        drive(ADD_, 10, 32'h1234, 32'h55, 1, AL, 1, 0, 0, 3, 2'b00);
        sb.push_back('{res: 32'h5F, wd: 32'h1234, rd: 3, rw: 1, m2r: 2'b00});
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL add_imm: out_valid=%b required 1", out_valid);
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || write_data !== e.wd) begin
                n_fail++;
                $display("FAIL add_imm: res=%h wd=%h required %h %h", alu_result, write_data, e.res, e.wd);
            end
        end
    endtask

    task automatic test_flags_branch();
        drive(CMP_, 5, 5, 0, 0, AL, 0, 1, 0, 0, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0110 || out_valid !== 1'b1 || alu_result !== 0) begin
            n_fail++; $display("FAIL cmp_eq: flags=%b valid=%b res=%h required 0110 1 0", flags, out_valid, alu_result);
        end
        drive(ADD_, 0, 0, 0, 0, EQ, 0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin
            n_fail++; $display("FAIL branch_eq: pc_src=%b required 1", pc_src);
        end
        tick();
        drive(ADD_, 1, 2, 0, 0, NE, 1, 0, 1, 3, 0);
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin
            n_fail++; $display("FAIL branch_ne: pc_src=%b required 0", pc_src);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || rw_out !== 1'b0) begin
            n_fail++; $display("FAIL ne_bubble: valid=%b rw=%b required 0 0", out_valid, rw_out);
        end
        drive(MUL_, 3, 3, 0, 0, NE, 1, 0, 0, 1, 0);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_condfail_busy: busy=%b required 0", busy);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_condfail: valid=%b busy=%b required 0 0", out_valid, busy);
        end
        clear_in();
    endtask

    task automatic test_overflow();
        drive(ADD_, 32'h7FFF_FFFF, 1, 0, 0, AL, 1, 1, 0, 2, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1001 || alu_result !== 32'h8000_0000) begin
            n_fail++; $display("FAIL add_ovf: flags=%b res=%h required 1001 80000000", flags, alu_result);
        end
        drive(ADD_, 0, 0, 0, 0, GE, 0, 0, 1, 0, 0);
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin
            n_fail++; $display("FAIL branch_ge: pc_src=%b required 1", pc_src);
        end
        tick();
        drive(SUB_, 0, 1, 0, 0, AL, 1, 1, 0, 4, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1000 || alu_result !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL sub_borrow: flags=%b res=%h required 1000 ffffffff", flags, alu_result);
        end
        drive(SUB_, 5, 5, 0, 0, GE, 1, 1, 0, 4, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ge_fail_flags: flags=%b valid=%b required 1000 0", flags, out_valid);
        end
        drive(ADD_, 32'hFFFF_FFFF, 1, 0, 0, LT, 1, 1, 0, 4, 0);
        tick();
        n_checks++;
        if (flags !== 4'b0110 || alu_result !== 0) begin
            n_fail++; $display("FAIL add_carry: flags=%b res=%h required 0110 0", flags, alu_result);
        end
        drive(EOR_, 32'h8000_0000, 0, 0, 0, AL, 1, 1, 0, 4, 0);
        tick();
        n_checks++;
        if (flags !== 4'b1010) begin
            n_fail++; $display("FAIL logic_nz_only: flags=%b required 1010", flags);
        end
        clear_in();
    endtask

    task automatic test_alu_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, imm;
        logic         src;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == MUL_) op = 4'b1001;
            a = $urandom; b = $urandom; imm = $urandom; src = 1'($urandom_range(0, 1));
            drive(op, a, b, imm, src, AL, 1, 0, 0, 4'(i), 2'(i));
            sb.push_back('{res: model_alu(op, a, src ? imm : b), wd: b, rd: 4'(i), rw: 1, m2r: 2'(i)});
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++; $display("FAIL alu_rand valid: op=%h out_valid=%b required 1", op, out_valid);
            end else begin
                e = sb.pop_front();
                if (alu_result !== e.res || write_data !== e.wd || rd_out !== e.rd || m2r_out !== e.m2r) begin
                    n_fail++;
                    $display("FAIL alu_rand op=%h a=%h b=%h: res=%h wd=%h required %h %h",
                             op, a, src ? imm : b, alu_result, write_data, e.res, e.wd);
                end
            end
        end
        clear_in();
    endtask

    task automatic test_mul();
        int lat, bad;
        // 7*6 with flags: 42 -> N=0,Z=0; C,V kept from 1010
        drive(MUL_, 7, 6, 0, 0, AL, 1, 1, 0, 5, 0);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mul_accept_busy: busy=%b required 1", busy);
        end
        sb.push_back('{res: 42, wd: 6, rd: 5, rw: 1, m2r: 0});
        lat = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid === 1'b1) begin lat = n; clear_in(); break; end
            if (busy !== 1'b1) bad++;
        end
        n_checks++;
        if (lat != 33 || bad != 0) begin
            n_fail++; $display("FAIL mul_latency: latency=%0d busy_gaps=%0d required 33 0", lat, bad);
        end
        n_checks++;
        if (sb.size() == 0 || lat == 0) begin
            n_fail++; $display("FAIL mul_result: no result observed, required 42");
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || rd_out !== e.rd || rw_out !== e.rw || flags !== 4'b0010) begin
                n_fail++; $display("FAIL mul_result: res=%0d rd=%0d flags=%b required %0d %0d 0010",
                                   alu_result, rd_out, flags, e.res, e.rd);
            end
        end
        // all-ones squared with immediate operand and a 3-cycle stall mid-run
        drive(MUL_, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFF, 1, AL, 1, 0, 0, 6, 0);
        sb.push_back('{res: 1, wd: 9, rd: 6, rw: 1, m2r: 0});
        lat = 0;
        for (int n = 1; n <= 45; n++) begin
            tick();
            if (out_valid === 1'b1) begin lat = n; clear_in(); break; end
            stall = (n >= 10 && n <= 12);
        end
        n_checks++;
        if (lat != 36) begin
            n_fail++; $display("FAIL mul_stall_latency: latency=%0d required 36", lat);
        end
        n_checks++;
        if (sb.size() == 0 || lat == 0) begin
            n_fail++; $display("FAIL mul_stall_result: no result observed, required 1");
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || write_data !== e.wd || flags !== 4'b0010) begin
                n_fail++; $display("FAIL mul_stall_result: res=%h wd=%h flags=%b required %h %h 0010",
                                   alu_result, write_data, flags, e.res, e.wd);
            end
        end
        clear_in();
        tick();
    endtask

    task automatic test_stall();
        drive(ADD_, 1, 2, 0, 0, AL, 1, 0, 0, 1, 0);
        tick();
        drive(ADD_, 4, 4, 0, 0, AL, 1, 0, 1, 2, 0);
        stall = 1;
        #1;
        n_checks++;
        if (busy !== 1'b1 || pc_src !== 1'b0) begin
            n_fail++; $display("FAIL stall_comb: busy=%b pc_src=%b required 1 0", busy, pc_src);
        end
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || alu_result !== 3 || rd_out !== 1) begin
            n_fail++; $display("FAIL stall_hold: valid=%b res=%0d rd=%0d required 1 3 1", out_valid, alu_result, rd_out);
        end
        stall = 0;
        #1;
        n_checks++;
        if (pc_src !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_branch: pc_src=%b required 1", pc_src);
        end
        sb.push_back('{res: 8, wd: 4, rd: 2, rw: 1, m2r: 0});
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL stall_release: out_valid=%b required 1", out_valid);
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || rd_out !== e.rd) begin
                n_fail++; $display("FAIL stall_release: res=%0d rd=%0d required %0d %0d", alu_result, rd_out, e.res, e.rd);
            end
        end
        clear_in();
    endtask

    task automatic test_flush();
        int stray;
        drive(MUL_, 9, 9, 0, 0, AL, 1, 1, 0, 7, 0);
        tick();
        for (int n = 0; n < 4; n++) tick();
        clear_in();
        flush = 1;
        tick();
        flush = 0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || flags !== 4'b0010) begin
            n_fail++; $display("FAIL flush_mul: valid=%b busy=%b flags=%b required 0 0 0010", out_valid, busy, flags);
        end
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (out_valid !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL flush_abort: stray_outputs=%0d required 0", stray);
        end
        drive(ADD_, 5, 6, 0, 0, AL, 1, 1, 1, 1, 0);
        flush = 1;
        #1;
        n_checks++;
        if (pc_src !== 1'b0) begin
            n_fail++; $display("FAIL flush_branch: pc_src=%b required 0", pc_src);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || rw_out !== 1'b0 || flags !== 4'b0010) begin
            n_fail++; $display("FAIL flush_single: valid=%b rw=%b flags=%b required 0 0 0010", out_valid, rw_out, flags);
        end
        clear_in();
    endtask

    task automatic test_reset_mid_mul();
        drive(MUL_, 2, 3, 0, 0, AL, 1, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        clear_in();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (flags !== 4'b0000 || out_valid !== 1'b0 || alu_result !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_mul: flags=%b valid=%b res=%h busy=%b required 0", flags, out_valid, alu_result, busy);
        end
        #1;
        rst = 1'b0;
        tick();
        drive(ADD_, 2, 2, 0, 0, AL, 1, 0, 0, 9, 0);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
        sb.push_back('{res: 4, wd: 2, rd: 9, rw: 1, m2r: 0});
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL reset_recover: out_valid=%b required 1", out_valid);
        end else begin
            e = sb.pop_front();
            if (alu_result !== e.res || rd_out !== e.rd) begin
                n_fail++; $display("FAIL reset_recover: res=%0d rd=%0d required %0d %0d", alu_result, rd_out, e.res, e.rd);
            end
        end
        clear_in();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_flags_branch();
        test_overflow();
        test_alu_random();
        test_mul();
        test_stall();
        test_flush();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
